pixel_row_readout: RTL

- Receiving end of the pixel-row READ phase.
- Snapshots the parallel row bus (PIXEL_ARRAY_WIDTH pixels x 8 bit) on the first clock of each `read` assertion.
- Streams the pixels out one per beat over a valid/ready interface, tagged with column/row indices and frame markers.
- Sits between PIXEL_ROW DATA_OUT and the downstream frame sink; double-buffered so a new row can arrive while the previous row is still draining.

---
 rtl/pixel_row_readout_pkg.sv | 17 +
 rtl/row_buffer_2deep.sv | 67 ++++++
 rtl/pixel_row_readout.sv | 96 +++++++++
 3 files changed

// File: rtl/pixel_row_readout_pkg.sv
// Shared pixel-row definitions so the row producer and this readout agree on geometry.
// Rows are packed pixel vectors with pixel 0 in the least significant byte.
package pixel_row_readout_pkg;

  localparam int PIXEL_ARRAY_WIDTH = 4;
  localparam int ROW_COUNT         = 4;
  localparam int PIXEL_W           = 8;

  typedef logic [PIXEL_W-1:0]             pixel_t;
  typedef pixel_t [PIXEL_ARRAY_WIDTH-1:0] row_t;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_buffer_2deep.sv
// Active/pending row storage: a capture fills whichever slot is free; advance promotes pending.
// Loads appear on the next cycle; a capture with both slots occupied is dropped and flagged.
module row_buffer_2deep #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic                  advance,
  input  logic [WIDTH-1:0][7:0] row_in,
  output logic [WIDTH-1:0][7:0] active_row,
  output logic                  active_valid,
  output logic                  pending_valid,
  output logic                  drop
);

  logic [WIDTH-1:0][7:0] pending_row;
  logic [WIDTH-1:0][7:0] active_row_nxt;
  logic [WIDTH-1:0][7:0] pending_row_nxt;
  logic                  active_valid_nxt;
  logic                  pending_valid_nxt;

  // Retire first, then place the capture, so a slot freed on this edge is reusable at once.
  always_comb begin
    active_row_nxt    = active_row;
    pending_row_nxt   = pending_row;
    active_valid_nxt  = active_valid;
    pending_valid_nxt = pending_valid;
    drop              = 1'b0;

    if (advance) begin
      if (pending_valid) begin
        active_row_nxt    = pending_row;
        pending_valid_nxt = 1'b0;
      end else begin
        active_valid_nxt  = 1'b0;
      end
    end

    if (capture) begin
      if (!active_valid_nxt) begin
        active_row_nxt    = row_in;
        active_valid_nxt  = 1'b1;
      end else if (!pending_valid_nxt) begin
        pending_row_nxt   = row_in;
        pending_valid_nxt = 1'b1;
      end else begin
        drop              = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_row    <= '0;
      pending_row   <= '0;
      active_valid  <= 1'b0;
      pending_valid <= 1'b0;
    end else begin
      active_row    <= active_row_nxt;
      pending_row   <= pending_row_nxt;
      active_valid  <= active_valid_nxt;
      pending_valid <= pending_valid_nxt;
    end
  end

endmodule

// File: rtl/pixel_row_readout.sv
// Captures a parallel pixel row on each read rising edge and streams it one pixel per beat.
// First beat one cycle after capture; beats hold while out_ready=0, a second row queues behind.
module pixel_row_readout #(
  parameter int PIXEL_ARRAY_WIDTH = pixel_row_readout_pkg::PIXEL_ARRAY_WIDTH,
  parameter int ROW_COUNT         = pixel_row_readout_pkg::ROW_COUNT,
  parameter int COL_W             = pixel_row_readout_pkg::idx_width(PIXEL_ARRAY_WIDTH),
  parameter int ROW_W             = pixel_row_readout_pkg::idx_width(ROW_COUNT)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              read,
  input  logic [PIXEL_ARRAY_WIDTH-1:0][7:0] row_data,
  output logic [7:0]                        out_data,
  output logic [COL_W-1:0]                  out_col,
  output logic [ROW_W-1:0]                  out_row,
  output logic                              out_sof,
  output logic                              out_eof,
  output logic                              out_eol,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              overrun,
  input  logic                              clear_overrun
);

  import pixel_row_readout_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(PIXEL_ARRAY_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROW_COUNT - 1);

  logic                              read_q;
  logic                              capture;
  logic                              beat;
  logic                              last_beat;
  logic                              drop;
  logic                              active_valid;
  logic                              pending_valid;
  logic [PIXEL_ARRAY_WIDTH-1:0][7:0] active_row;
  logic [COL_W-1:0]                  col;
  logic [ROW_W-1:0]                  row;
  pixel_t                            pixel;

  assign capture   = read && !read_q;
  assign beat      = active_valid && out_ready;
  assign last_beat = beat && (col == LAST_COL);

  row_buffer_2deep #(
    .WIDTH         (PIXEL_ARRAY_WIDTH)
  ) u_row_buffer (
    .clk           (clk),
    .reset         (reset),
    .capture       (capture),
    .advance       (last_beat),
    .row_in        (row_data),
    .active_row    (active_row),
    .active_valid  (active_valid),
    .pending_valid (pending_valid),
    .drop          (drop)
  );

  // Row index only moves when a row actually finishes streaming, so dropped rows never count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_q  <= 1'b0;
      col     <= '0;
      row     <= '0;
      overrun <= 1'b0;
    end else begin
      read_q <= read;
      if (beat) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  assign pixel     = active_row[col];
  assign out_data  = pixel;
  assign out_col   = col;
  assign out_row   = row;
  assign out_valid = active_valid;
  assign out_sof   = active_valid && (row == '0) && (col == '0);
  assign out_eol   = active_valid && (col == LAST_COL);
  assign out_eof   = out_eol && (row == LAST_ROW);
  assign busy      = active_valid || pending_valid;

endmodule
